// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic conflict monitor: lamp encoding,
// fault codes, monitor states and small lamp helpers.
package tlc_pkg;

  typedef enum logic [1:0] {
    LAMP_INVALID = 2'b00,
    LAMP_RED     = 2'b01,
    LAMP_GREEN   = 2'b10,
    LAMP_YELLOW  = 2'b11
  } lamp_e;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'b00,
    ST_MONITOR = 2'b01,
    ST_FAULT   = 2'b10
  } mon_state_e;

  localparam logic [2:0] CODE_NONE     = 3'b000;
  localparam logic [2:0] CODE_CONFLICT = 3'b001;
  localparam logic [2:0] CODE_ONEHOT   = 3'b010;
  localparam logic [2:0] CODE_SEQUENCE = 3'b011;
  localparam logic [2:0] CODE_YELLOW   = 3'b100;

  function automatic lamp_e decodeLamp(input logic green, input logic yellow, input logic red);
    lamp_e lamp;
    case ({green, yellow, red})
      3'b100:  lamp = LAMP_GREEN;
      3'b010:  lamp = LAMP_YELLOW;
      3'b001:  lamp = LAMP_RED;
      default: lamp = LAMP_INVALID;
    endcase
    return lamp;
  endfunction

  // Only green->red, yellow->green and red->yellow break the lamp cycle.
  function automatic logic isIllegalStep(input lamp_e prevLamp, input lamp_e curLamp);
    return (prevLamp == LAMP_GREEN  && curLamp == LAMP_RED)   ||
           (prevLamp == LAMP_YELLOW && curLamp == LAMP_GREEN) ||
           (prevLamp == LAMP_RED    && curLamp == LAMP_YELLOW);
  endfunction

endpackage

// File: rtl/lamp_checker.sv
// Per-street lamp checks: one-hot decode, previous-lamp register,
// sequence check and saturating yellow-duration counter.
module lamp_checker #(
  parameter int MAX_YELLOW = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_green,
  input  logic i_yellow,
  input  logic i_red,
  input  logic i_sample,
  input  logic i_seqEn,
  input  logic i_clear,
  output logic o_oneHotErr,
  output logic o_seqErr,
  output logic o_yellowOverrun
);
  import tlc_pkg::*;

  localparam int YW = $clog2(MAX_YELLOW + 2);
  localparam logic [YW-1:0] Y_SAT = YW'(MAX_YELLOW + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(MAX_YELLOW);

  lamp_e          w_lamp;
  lamp_e          r_prevLamp;
  logic [YW-1:0]  r_yCnt;

  assign w_lamp          = decodeLamp(i_green, i_yellow, i_red);
  assign o_oneHotErr     = (w_lamp == LAMP_INVALID);
  assign o_seqErr        = i_seqEn && (r_prevLamp != LAMP_INVALID) && (w_lamp != LAMP_INVALID) &&
                           isIllegalStep(r_prevLamp, w_lamp);
  assign o_yellowOverrun = i_seqEn && i_yellow && (r_yCnt >= Y_MAX);

  // Yellow run only accumulates while sequence checking is live, so the
  // startup sample never contributes to an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prevLamp <= LAMP_INVALID;
      r_yCnt     <= '0;
    end else if (i_clear) begin
      r_yCnt     <= '0;
    end else if (i_sample) begin
      r_prevLamp <= w_lamp;
      if (!i_seqEn || !i_yellow)
        r_yCnt <= '0;
      else if (r_yCnt != Y_SAT)
        r_yCnt <= r_yCnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Traffic-light conflict monitor: merges per-street lamp checks, prioritises
// fault causes, latches the first fault and drives a flashing-red command.
module traffic_conflict_monitor #(
  parameter int MAX_YELLOW = 4,
  parameter int FLASH_HALF = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       GA,
  input  logic       YA,
  input  logic       RA,
  input  logic       GB,
  input  logic       YB,
  input  logic       RB,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_red,
  output logic       monitor_ok
);
  import tlc_pkg::*;

  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  mon_state_e    r_state, w_nextState;
  logic [2:0]    r_code, w_nextCode, w_detCode;
  logic          r_flash, w_nextFlash;
  logic [FW-1:0] r_flashCnt, w_nextFlashCnt;

  logic w_sample, w_seqEn, w_clear, w_conflict;
  logic w_oneHotA, w_seqA, w_yOvrA;
  logic w_oneHotB, w_seqB, w_yOvrB;

  assign w_sample   = (r_state != ST_FAULT);
  assign w_seqEn    = (r_state == ST_MONITOR);
  assign w_clear    = (r_state == ST_FAULT) && clear_fault;
  assign w_conflict = (GA | YA) & (GB | YB);

  lamp_checker #(.MAX_YELLOW(MAX_YELLOW)) u_checkA (
    .clk(clk), .reset_n(reset_n),
    .i_green(GA), .i_yellow(YA), .i_red(RA),
    .i_sample(w_sample), .i_seqEn(w_seqEn), .i_clear(w_clear),
    .o_oneHotErr(w_oneHotA), .o_seqErr(w_seqA), .o_yellowOverrun(w_yOvrA)
  );

  lamp_checker #(.MAX_YELLOW(MAX_YELLOW)) u_checkB (
    .clk(clk), .reset_n(reset_n),
    .i_green(GB), .i_yellow(YB), .i_red(RB),
    .i_sample(w_sample), .i_seqEn(w_seqEn), .i_clear(w_clear),
    .o_oneHotErr(w_oneHotB), .o_seqErr(w_seqB), .o_yellowOverrun(w_yOvrB)
  );

  always_comb begin
    w_detCode = CODE_NONE;
    if (w_conflict)
      w_detCode = CODE_CONFLICT;
    else if (w_oneHotA || w_oneHotB)
      w_detCode = CODE_ONEHOT;
    else if (w_seqA || w_seqB)
      w_detCode = CODE_SEQUENCE;
    else if (w_yOvrA || w_yOvrB)
      w_detCode = CODE_YELLOW;
  end

  // FAULT ignores lamps entirely; only clear_fault or reset leaves it.
  always_comb begin
    w_nextState    = r_state;
    w_nextCode     = r_code;
    w_nextFlash    = r_flash;
    w_nextFlashCnt = r_flashCnt;
    case (r_state)
      ST_STARTUP, ST_MONITOR: begin
        if (w_detCode != CODE_NONE) begin
          w_nextState    = ST_FAULT;
          w_nextCode     = w_detCode;
          w_nextFlash    = 1'b1;
          w_nextFlashCnt = '0;
        end else begin
          w_nextState    = ST_MONITOR;
        end
      end
      ST_FAULT: begin
        if (clear_fault) begin
          w_nextState    = ST_STARTUP;
          w_nextCode     = CODE_NONE;
          w_nextFlash    = 1'b0;
          w_nextFlashCnt = '0;
        end else if (r_flashCnt == FLASH_LAST) begin
          w_nextFlash    = ~r_flash;
          w_nextFlashCnt = '0;
        end else begin
          w_nextFlashCnt = r_flashCnt + 1'b1;
        end
      end
      default: w_nextState = ST_STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_STARTUP;
      r_code     <= CODE_NONE;
      r_flash    <= 1'b0;
      r_flashCnt <= '0;
    end else begin
      r_state    <= w_nextState;
      r_code     <= w_nextCode;
      r_flash    <= w_nextFlash;
      r_flashCnt <= w_nextFlashCnt;
    end
  end

  assign fault      = (r_state == ST_FAULT);
  assign monitor_ok = (r_state == ST_MONITOR);
  assign fault_code = r_code;
  assign flash_red  = r_flash;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Randomised and directed bench for traffic_conflict_monitor, checked every
// cycle against a lamp-rule model plus hand-computed scenario expectations.
module tb_traffic_conflict_monitor;

  localparam int MAX_YELLOW = 4;
  localparam int FLASH_HALF = 25;

  localparam logic [5:0] AG_BR = 6'b100_001;
  localparam logic [5:0] AY_BR = 6'b010_001;
  localparam logic [5:0] AR_BG = 6'b001_100;
  localparam logic [5:0] AR_BY = 6'b001_010;
  localparam logic [5:0] AR_BR = 6'b001_001;
  localparam logic [5:0] AG_BG = 6'b100_100;

  localparam int M_START = 0;
  localparam int M_MON   = 1;
  localparam int M_FAULT = 2;

  typedef struct packed {
    int  mode;
    byte prevA;
    byte prevB;
    int  yRunA;
    int  yRunB;
    int  code;
    int  age;
  } model_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] lamps = AR_BR;
  logic       clear_fault = 1'b0;
  logic       GA, YA, RA, GB, YB, RB;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_red;
  logic       monitor_ok;

  model_t m;
  int     passCount = 0;
  int     totalCount = 0;
  bit     checkEn = 1'b0;

  assign {GA, YA, RA, GB, YB, RB} = lamps;

  always #5 clk = ~clk;

  traffic_conflict_monitor #(.MAX_YELLOW(MAX_YELLOW), .FLASH_HALF(FLASH_HALF)) dut (
    .clk(clk), .reset_n(reset_n),
    .GA(GA), .YA(YA), .RA(RA), .GB(GB), .YB(YB), .RB(RB),
    .clear_fault(clear_fault),
    .fault(fault), .fault_code(fault_code), .flash_red(flash_red), .monitor_ok(monitor_ok)
  );

  function automatic byte lampOf(input logic g, input logic y, input logic r);
    case ({g, y, r})
      3'b100:  return "G";
      3'b010:  return "Y";
      3'b001:  return "R";
      default: return "X";
    endcase
  endfunction

  function automatic bit badStep(input byte p, input byte c);
    return (p == "G" && c == "R") || (p == "Y" && c == "G") || (p == "R" && c == "Y");
  endfunction

  function automatic model_t modelReset();
    model_t r;
    r.mode = M_START; r.prevA = "X"; r.prevB = "X";
    r.yRunA = 0; r.yRunB = 0; r.code = 0; r.age = 0;
    return r;
  endfunction

  function automatic model_t modelStep(input model_t cur, input logic [5:0] l, input logic clr);
    model_t nxt;
    byte la, lb;
    int  c;
    nxt = cur;
    if (cur.mode == M_FAULT) begin
      if (clr) begin
        nxt.mode = M_START; nxt.code = 0; nxt.age = 0; nxt.yRunA = 0; nxt.yRunB = 0;
      end else begin
        nxt.age = cur.age + 1;
      end
      return nxt;
    end
    la = lampOf(l[5], l[4], l[3]);
    lb = lampOf(l[2], l[1], l[0]);
    c = 0;
    if ((l[5] | l[4]) & (l[2] | l[1]))
      c = 1;
    else if (la == "X" || lb == "X")
      c = 2;
    else if (cur.mode == M_MON && (badStep(cur.prevA, la) || badStep(cur.prevB, lb)))
      c = 3;
    else if (cur.mode == M_MON && ((la == "Y" && cur.yRunA + 1 > MAX_YELLOW) ||
                                   (lb == "Y" && cur.yRunB + 1 > MAX_YELLOW)))
      c = 4;
    nxt.prevA = la;
    nxt.prevB = lb;
    nxt.yRunA = (cur.mode == M_MON && la == "Y") ? cur.yRunA + 1 : 0;
    nxt.yRunB = (cur.mode == M_MON && lb == "Y") ? cur.yRunB + 1 : 0;
    if (c != 0) begin
      nxt.mode = M_FAULT; nxt.code = c; nxt.age = 0;
    end else begin
      nxt.mode = M_MON;
    end
    return nxt;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalCount++;
    if (actual == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [5:0] l, input logic clr);
    @(negedge clk);
    lamps = l;
    clear_fault = clr;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      m <= modelReset();
    else
      m <= modelStep(m, lamps, clear_fault);
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("fault", int'(fault), int'(m.mode == M_FAULT));
      checkOutput("fault_code", int'(fault_code), m.code);
      checkOutput("flash_red", int'(flash_red),
                  int'(m.mode == M_FAULT && ((m.age / FLASH_HALF) % 2) == 0));
      checkOutput("monitor_ok", int'(monitor_ok), int'(m.mode == M_MON));
    end
  end

  initial begin
    int         phase;
    int         left;
    logic [5:0] l;

    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("lit_reset_fault", int'(fault), 0);
    checkOutput("lit_reset_code", int'(fault_code), 0);
    checkOutput("lit_reset_flash", int'(flash_red), 0);
    checkOutput("lit_reset_ok", int'(monitor_ok), 0);

    // Legal two-street cycle; the first sample after release is the startup one.
    applyStimulus(AG_BR, 1'b0);
    reset_n = 1'b1;
    applyStimulus(AG_BR, 1'b0);
    checkOutput("lit_ok_after_startup", int'(monitor_ok), 1);
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < ((rep == 0) ? 3 : 5); i++) applyStimulus(AG_BR, 1'b0);
      applyStimulus(AY_BR, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(AR_BG, 1'b0);
      applyStimulus(AR_BY, 1'b0);
    end
    applyStimulus(AG_BR, 1'b0);
    checkOutput("lit_legal_fault", int'(fault), 0);
    checkOutput("lit_legal_ok", int'(monitor_ok), 1);

    applyStimulus(AG_BG, 1'b0);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_conflict_fault", int'(fault), 1);
    checkOutput("lit_conflict_code", int'(fault_code), 1);
    checkOutput("lit_conflict_ok", int'(monitor_ok), 0);
    checkOutput("lit_conflict_flash", int'(flash_red), 1);
    applyStimulus(AR_BR, 1'b1);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_clear_fault", int'(fault), 0);
    checkOutput("lit_clear_code", int'(fault_code), 0);
    checkOutput("lit_clear_startup_ok", int'(monitor_ok), 0);
    applyStimulus(AG_BR, 1'b0);
    checkOutput("lit_clear_monitor_ok", int'(monitor_ok), 1);

    applyStimulus(AR_BR, 1'b0);
    applyStimulus(AG_BG, 1'b0);
    checkOutput("lit_seq_code", int'(fault_code), 3);
    applyStimulus(AG_BG, 1'b0);
    applyStimulus(AG_BG, 1'b0);
    checkOutput("lit_seq_code_held", int'(fault_code), 3);
    checkOutput("lit_seq_fault_held", int'(fault), 1);
    applyStimulus(AR_BR, 1'b1);
    applyStimulus(AR_BR, 1'b0);

    applyStimulus(AR_BG, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(AR_BY, 1'b0);
    checkOutput("lit_yellow4_code", int'(fault_code), 0);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_yellow5_code", int'(fault_code), 4);
    checkOutput("lit_flash_entry", int'(flash_red), 1);
    for (int k = 1; k <= 50; k++) begin
      applyStimulus(AR_BR, 1'b0);
      if (k == 24) checkOutput("lit_flash_k24", int'(flash_red), 1);
      if (k == 25) checkOutput("lit_flash_k25", int'(flash_red), 0);
      if (k == 49) checkOutput("lit_flash_k49", int'(flash_red), 0);
      if (k == 50) checkOutput("lit_flash_k50", int'(flash_red), 1);
    end
    applyStimulus(AR_BR, 1'b1);
    applyStimulus(AR_BR, 1'b0);
    applyStimulus(AR_BR, 1'b0);

    applyStimulus(6'b011_100, 1'b0);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_priority_code", int'(fault_code), 1);
    applyStimulus(AR_BR, 1'b1);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_prio_clear_fault", int'(fault), 0);
    checkOutput("lit_prio_startup_ok", int'(monitor_ok), 0);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_prio_monitor_ok", int'(monitor_ok), 1);

    applyStimulus(AR_BR, 1'b1);
    applyStimulus(AR_BR, 1'b1);
    applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_clear_ignored_ok", int'(monitor_ok), 1);
    checkOutput("lit_clear_ignored_fault", int'(fault), 0);

    applyStimulus(AG_BG, 1'b0);
    repeat (3) applyStimulus(AR_BR, 1'b0);
    checkOutput("lit_pre_reset_fault", int'(fault), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("lit_async_fault", int'(fault), 0);
    checkOutput("lit_async_code", int'(fault_code), 0);
    checkOutput("lit_async_flash", int'(flash_red), 0);
    checkOutput("lit_async_ok", int'(monitor_ok), 0);
    applyStimulus(AR_BR, 1'b0);
    applyStimulus(AG_BR, 1'b0);
    reset_n = 1'b1;

    // Mostly-legal random controller with injected corruption, yellow overruns and clears.
    phase = 0;
    left  = 4;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (left == 0) begin
        phase = (phase + 1) % 4;
        left  = (phase % 2 == 0) ? $urandom_range(1, 8) : $urandom_range(1, MAX_YELLOW + 1);
      end
      case (phase)
        0:       l = AG_BR;
        1:       l = AY_BR;
        2:       l = AR_BG;
        default: l = AR_BY;
      endcase
      left--;
      if ($urandom_range(0, 39) == 0) l = 6'($urandom);
      applyStimulus(l, $urandom_range(0, 7) == 0);
    end

    applyStimulus(AR_BR, 1'b0);
    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter MAX_YELLOW, default 4: maximum consecutive cycles any yellow lamp may be sampled lit.
REQ-002 Parameter FLASH_HALF, default 25: cycles per half-period of the flashing-red output.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 GA, YA, RA  input  1 each  street A lamp drives from the controller.
REQ-006 GB, YB, RB  input  1 each  street B lamp drives from the controller.
REQ-007 clear_fault  input  1  operator acknowledge; acts only in FAULT.
REQ-008 fault  output  1  high while in FAULT.
REQ-009 fault_code  output  3  latched cause: 000 none, 001 conflict, 010 lamp not one-hot, 011 illegal sequence, 100 yellow overrun.
REQ-010 flash_red  output  1  flashing all-red command; 0 outside FAULT.
REQ-011 monitor_ok  output  1  high only in MONITOR.

Function
REQ-012 States: STARTUP, MONITOR, FAULT.
REQ-013 Lamps are sampled every cycle; a fault detected in sample N drives fault=1 and fault_code in cycle N+1, which is 1-cycle latency.
REQ-014 Conflict check: (GA|YA)&(GB|YB) sets code 001.
REQ-015 One-hot check: for each street, exactly one of G/Y/R lit; zero or two or more lit sets code 010.
REQ-016 Sequence check, per street, against the previous sample: G->G, G->Y, Y->Y, Y->R, R->R and R->G are legal; G->R, Y->G and R->Y set code 011.
REQ-017 Yellow overrun: a per-street counter counts consecutive lit-yellow samples and clears when yellow is unlit; the sample that makes the count exceed MAX_YELLOW sets code 100.
REQ-018 Simultaneous causes: the lowest nonzero code wins (001 > 010 > 011 > 100).
REQ-019 STARTUP lasts exactly one cycle: it captures the previous-lamp registers, applies REQ-014 and REQ-015, and skips REQ-016 and REQ-017; with no fault it goes to MONITOR.
REQ-020 MONITOR applies all checks; any fault goes to FAULT.
REQ-021 FAULT is latched: lamp inputs are ignored, fault_code holds its first cause, and later faults are discarded.
REQ-022 FAULT flash: flash_red goes to 1 on entry, toggles every FLASH_HALF cycles, and the counter restarts on entry.
REQ-023 clear_fault=1 in FAULT goes to STARTUP next cycle, clearing fault, fault_code, flash_red, the yellow counters and the flash counter.
REQ-024 clear_fault in STARTUP or MONITOR has no effect.
REQ-025 The yellow counters saturate at MAX_YELLOW+1, with no wrap.
REQ-026 Counter widths are sized from the parameters ($clog2), with no truncation.

Reset
REQ-027 Reset asserted forces STARTUP, fault=0, fault_code=000, flash_red=0, monitor_ok=0, and clears all counters and previous-lamp registers, asynchronously, at any time including mid-FAULT.
REQ-028 The first sample after reset release is treated as STARTUP.

Structure
REQ-029 Shared package tlc_pkg holds: the lamp encoding (RED, GREEN, YELLOW, INVALID), the fault-code constants, and the monitor state encoding.
REQ-030 Sub-module lamp_checker, instantiated once per street, provides: one-hot decode, previous-lamp register, sequence check and yellow counter; it reports flags to the top, which owns priority, FSM and flash.
REQ-031 Outputs are registered, with no combinational path from inputs to outputs.

Verification
REQ-032 Legal cycle A-green 5, A-yellow 1, B-green 5, B-yellow 1, repeated 3 times -> monitor_ok=1 from cycle 2 onward and fault=0 throughout.
REQ-033 GA=1 and GB=1 in the same cycle during MONITOR -> fault=1 and fault_code=001 next cycle; monitor_ok=0.
REQ-034 GA=1 then RA=1 with no yellow between, B lamps valid -> fault_code=011; later GA+GB conflicts keep 011.
REQ-035 YB held 5 cycles with MAX_YELLOW=4 -> fault_code=100 one cycle after the 5th sample; flash_red=1 for 25 cycles, then 0 for 25 cycles.
REQ-036 RA=YA=1 and GB=1 on the same sample -> code 010 loses to conflict, so fault_code=001; then clear_fault=1 -> fault=0, STARTUP for one cycle, then MONITOR.
REQ-037 reset_n pulsed low mid-FAULT -> all outputs 0 immediately, without waiting for a clock edge.
